reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-result scoreboard in the ID stage of the pipelined MIPS core. It is the writer-side complement of the EX-stage forwarding logic. It records, per architectural register, how many cycles remain until an in-flight producer's result becomes forwardable. It stalls issue of any consumer or overwriting producer whose operands are not yet reachable through the EX/MEM or MEM/WB bypass. It covers load-use and multi-cycle (mul/div) hazards, so forwarding only ever sees ready data.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- LAT_W, 3, width of each countdown and of id_lat; max latency 2^LAT_W-1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  5  source register A.
- id_rs_used  input  1  instruction reads rs.
- id_rt  input  5  source register B.
- id_rt_used  input  1  instruction reads rt.
- id_rd  input  5  destination register.
- id_reg_write  input  1  instruction writes id_rd.
- id_lat  input  LAT_W  cycles after issue before the result is forwardable: 0 = ALU, 1 = load, n = multi-cycle unit.
- id_flush  input  1  ID instruction is being squashed; it must not issue.
- pipe_freeze  input  1  global pipeline hold (memory stall); scoreboard state holds.
- id_stall  output  1  hold PC and IF/ID, inject bubble into ID/EX.
- busy_mask  output  NUM_REGS  bit i = register i has nonzero countdown; bit 0 always 0.
- stall_count  output  32  present only with SB_PERF_CNT_EN.

## Operation
- State: one LAT_W countdown cnt[i] per register 1..NUM_REGS-1; busy[i] = (cnt[i] != 0).
- Hazard terms (combinational from current state and ID inputs):
  - raw = id_rs_used && id_rs!=0 && busy[id_rs], OR the same condition on rt.
  - waw = id_reg_write && id_rd!=0 && busy[id_rd].
- id_stall = id_valid && !id_flush && (raw || waw). id_stall is not gated by pipe_freeze.
- issue = id_valid && !id_flush && !id_stall && !pipe_freeze.
- Per-cycle update when pipe_freeze=0:
  - Every nonzero cnt decrements by 1.
  - On issue with id_reg_write and id_rd!=0, cnt[id_rd] loads id_lat; the load overrides the decrement for that entry.
  - id_lat=0 leaves the entry at 0, so no tracking is needed.
- pipe_freeze=1: all cnt hold; no load.
- Writes to register 0 are ignored. Reads of register 0 never stall.
- Countdown saturates at 0 and never wraps.

## Timing
- Reset (rst_n=0 at edge): all cnt=0, busy_mask=0, stall_count=0. id_stall then evaluates to 0 for any input.
- Reset mid-operation discards all pending entries. Upstream flushes the pipe at the same time.
- id_stall and busy_mask are combinational from registered state, valid in the same cycle as the ID inputs.
- Load (id_lat=1) issued in cycle N: cnt=1 in N+1, so a dependent in ID at N+1 stalls exactly 1 cycle and issues at N+2.
- Latency-L producer: a dependent directly behind it stalls L cycles.
- Stall and release: the same ID instruction re-evaluates each cycle; no sticky stall state.
- Simultaneous issue to rd=k while cnt[k]=1 cannot occur, because waw stalls it.

## Configuration
- SB_PERF_CNT_EN defined:
  - 32-bit stall_count increments each cycle id_stall=1 && pipe_freeze=0.
  - It wraps at 2^32-1 to 0 and resets to 0.
- SB_PERF_CNT_EN undefined: stall_count port and counter are absent; all other behaviour is identical.

## Structure
- Shared package mips_sb_pkg holds:
  - NUM_REGS and LAT_W defaults.
  - Latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=4, LAT_DIV=7.
- One sub-module, sb_entry: a single countdown with load, freeze, synchronous active-low reset, and a busy output. It is instantiated for registers 1..NUM_REGS-1; the top holds hazard compare, stall, and perf counter.

## Test plan
- Reset: hold rst_n=0 two cycles with id_valid=1, rs=rt=rd=5 -> id_stall=0, busy_mask=0, stall_count=0.
- Load-use: issue lw rd=8 lat=1, next cycle add reads rs=8 -> id_stall=1 one cycle, busy_mask[8]=1, then issue; stall_count=1.
- Multi-cycle: issue mul rd=3 lat=4, next cycle consumer rt=3 -> stalls 4 consecutive cycles. A consumer with rd=3 reads also stalls on waw.
- Register zero: lw rd=0 lat=1, then consumer rs=0 -> no stall, busy_mask=0.
- Freeze: lat=4 to rd=9, then pipe_freeze=1 for 3 cycles -> cnt[9] holds at 4, stall_count unchanged; it resumes its countdown after freeze drops.
- Flush: id_flush=1 with id_reg_write=1 rd=12 lat=1 -> no load, busy_mask[12]=0, id_stall=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the ID-stage register scoreboard: default sizing and
// the result latencies of each functional unit class.
package mips_sb_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_LAT_W    = 3;

  // Cycles after issue before a result can be taken from a bypass path.
  localparam logic [DEF_LAT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [DEF_LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [DEF_LAT_W-1:0] LAT_MUL  = 3'd4;
  localparam logic [DEF_LAT_W-1:0] LAT_DIV  = 3'd7;

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle. stall_count exists only when
// SB_PERF_CNT_EN is defined.
interface reg_scoreboard_if
  import mips_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int LAT_W    = DEF_LAT_W
);
  logic                id_valid;
  logic [4:0]          id_rs;
  logic                id_rs_used;
  logic [4:0]          id_rt;
  logic                id_rt_used;
  logic [4:0]          id_rd;
  logic                id_reg_write;
  logic [LAT_W-1:0]    id_lat;
  logic                id_flush;
  logic                pipe_freeze;
  logic                id_stall;
  logic [NUM_REGS-1:0] busy_mask;
`ifdef SB_PERF_CNT_EN
  logic [31:0]         stall_count;
`endif

  // Handshake: there is no valid/ready pair. id_valid qualifies the ID
  // instruction; id_stall is the scoreboard's "not ready" answer in the same
  // cycle, and an instruction issues only on id_valid && !id_flush &&
  // !id_stall && !pipe_freeze at the rising edge.
  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
           id_reg_write, id_lat, id_flush, pipe_freeze,
    input  id_stall, busy_mask
`ifdef SB_PERF_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
           id_reg_write, id_lat, id_flush, pipe_freeze,
    output id_stall, busy_mask
`ifdef SB_PERF_CNT_EN
    , output stall_count
`endif
  );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard countdown: loads a latency, counts down to zero and holds
// while the pipeline is frozen.
module sb_entry
  import mips_sb_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      // A new producer replaces whatever countdown was running.
      if (load_i)
        cnt_d = lat_i;
      else if (cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: stalls consumers and overwriting producers
// until results are reachable through the bypass. Optional stall counter
// under SB_PERF_CNT_EN.
module reg_scoreboard
  import mips_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int LAT_W    = DEF_LAT_W
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] busy_w;
  logic                raw_w;
  logic                waw_w;
  logic                issue_w;

  assign busy_w[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic load_w;
    assign load_w = issue_w && sb.id_reg_write && (sb.id_rd == 5'(i));

    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .freeze_i (sb.pipe_freeze),
      .load_i   (load_w),
      .lat_i    (sb.id_lat),
      .busy_o   (busy_w[i])
    );
  end

  // busy_w[0] is constant 0, so register 0 never causes a hazard.
  assign raw_w = (sb.id_rs_used && busy_w[sb.id_rs]) ||
                 (sb.id_rt_used && busy_w[sb.id_rt]);
  assign waw_w = sb.id_reg_write && busy_w[sb.id_rd];

  assign sb.id_stall  = sb.id_valid && !sb.id_flush && (raw_w || waw_w);
  assign issue_w      = sb.id_valid && !sb.id_flush && !sb.id_stall && !sb.pipe_freeze;
  assign sb.busy_mask = busy_w;

`ifdef SB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (sb.id_stall && !sb.pipe_freeze)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign sb.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard: hand-computed stall/busy vectors,
// stall_count checked when SB_PERF_CNT_EN is defined.
module tb_reg_scoreboard;
  import mips_sb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_scoreboard_if #(.NUM_REGS(32), .LAT_W(3)) sb_if ();

  reg_scoreboard #(.NUM_REGS(32), .LAT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] rs, input logic rs_used,
                       input logic [4:0] rt, input logic rt_used, input logic [4:0] rd,
                       input logic wr, input logic [2:0] lat, input logic flush,
                       input logic freeze);
    sb_if.id_valid     = valid;
    sb_if.id_rs        = rs;
    sb_if.id_rs_used   = rs_used;
    sb_if.id_rt        = rt;
    sb_if.id_rt_used   = rt_used;
    sb_if.id_rd        = rd;
    sb_if.id_reg_write = wr;
    sb_if.id_lat       = lat;
    sb_if.id_flush     = flush;
    sb_if.pipe_freeze  = freeze;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, LAT_ALU, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] exp);
`ifdef SB_PERF_CNT_EN
    check(tag, sb_if.stall_count, exp);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // reset held two cycles with a would-be producer/consumer in ID
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, LAT_LOAD, 1'b0, 1'b0);
    step();
    step();
    check("reset_stall", 32'(sb_if.id_stall), 32'd0);
    check("reset_busy", sb_if.busy_mask, 32'd0);
    check_perf("reset_perf", 32'd0);
    idle();
    rst_n = 1'b1;
    step();

    // load-use: lw r8, then add reads r8
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, LAT_LOAD, 1'b0, 1'b0);
    check("lw_issue_stall", 32'(sb_if.id_stall), 32'd0);
    step();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, LAT_ALU, 1'b0, 1'b0);
    check("lu_stall", 32'(sb_if.id_stall), 32'd1);
    check("lu_busy", sb_if.busy_mask, 32'h0000_0100);
    step();
    check("lu_release", 32'(sb_if.id_stall), 32'd0);
    check("lu_busy_clr", sb_if.busy_mask, 32'd0);
    step();
    idle();
    check_perf("lu_perf", 32'd1);

    // multi-cycle: mul r3 lat 4, consumer reads rt=3 stalls 4 cycles
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, LAT_MUL, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd11, 1'b1, LAT_ALU, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_stall_%0d", i), 32'(sb_if.id_stall), 32'd1);
      check($sformatf("mul_busy_%0d", i), sb_if.busy_mask, 32'h0000_0008);
      step();
    end
    check("mul_release", 32'(sb_if.id_stall), 32'd0);
    step();
    check_perf("mul_perf", 32'd5);

    // waw: producer r3 lat 2, then writer of r3 with no reads
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, LAT_ALU, 1'b0, 1'b0);
    check("waw_stall_0", 32'(sb_if.id_stall), 32'd1);
    step();
    check("waw_stall_1", 32'(sb_if.id_stall), 32'd1);
    step();
    check("waw_release", 32'(sb_if.id_stall), 32'd0);
    step();
    idle();
    check_perf("waw_perf", 32'd7);

    // register zero: lw r0 is never tracked, reads of r0 never stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, LAT_LOAD, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, LAT_ALU, 1'b0, 1'b0);
    check("r0_stall", 32'(sb_if.id_stall), 32'd0);
    check("r0_busy", sb_if.busy_mask, 32'd0);
    step();
    idle();

    // freeze: r9 lat 4, consumer held 3 frozen cycles, then exactly 4 stalls
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_MUL, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, LAT_ALU, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("frz_stall_%0d", i), 32'(sb_if.id_stall), 32'd1);
      check($sformatf("frz_busy_%0d", i), sb_if.busy_mask, 32'h0000_0200);
      step();
    end
    check_perf("frz_perf", 32'd7);
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, LAT_ALU, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("thaw_stall_%0d", i), 32'(sb_if.id_stall), 32'd1);
      step();
    end
    check("thaw_release", 32'(sb_if.id_stall), 32'd0);
    step();
    idle();
    check_perf("thaw_perf", 32'd11);

    // freeze blocks a load from an otherwise issuable producer
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, LAT_LOAD, 1'b0, 1'b1);
    step();
    idle();
    check("frz_noload", sb_if.busy_mask, 32'd0);

    // flush: squashed producer does not load
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_LOAD, 1'b1, 1'b0);
    check("flush_stall", 32'(sb_if.id_stall), 32'd0);
    step();
    idle();
    check("flush_busy", sb_if.busy_mask, 32'd0);

    // overlapping producers r20 (lat 2) and r21 (lat 1); flushed reader of r20
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 3'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, LAT_LOAD, 1'b0, 1'b0);
    check("ovl_busy_0", sb_if.busy_mask, 32'h0010_0000);
    step();
    drive(1'b1, 5'd20, 1'b1, 5'd21, 1'b1, 5'd0, 1'b0, LAT_ALU, 1'b1, 1'b0);
    check("ovl_busy_1", sb_if.busy_mask, 32'h0030_0000);
    check("ovl_flush_stall", 32'(sb_if.id_stall), 32'd0);
    step();
    idle();
    check("ovl_busy_2", sb_if.busy_mask, 32'd0);

    // reset mid-operation discards a pending divide
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, LAT_DIV, 1'b0, 1'b0);
    step();
    idle();
    check("div_busy", sb_if.busy_mask, 32'h0000_0080);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_busy", sb_if.busy_mask, 32'd0);
    check_perf("rst_mid_perf", 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
